// File: rtl/hs4_rx_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs4_rx_buffer_if : send/ack word handshake plus valid/ready FIFO drain port
// Revision 1.0
// ---------------------------------------------------------------------------
interface hs4_rx_buffer_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  logic                       send_i;
  logic [DATA_W-1:0]          data_i;
  logic                       ack_o;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       protocol_err;

  modport slave (
    input  send_i, data_i, out_ready,
    output ack_o, out_valid, out_data, count, protocol_err
  );

  modport master (
    output send_i, data_i, out_ready,
    input  ack_o, out_valid, out_data, count, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/hs4_rx_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs4_rx_buffer : 4-phase handshake responder feeding a FWFT FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module hs4_rx_buffer #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hs4_rx_buffer_if.slave bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_n;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_send_s;
  logic                     r_ack;
  logic                     r_err;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_err_set;
  logic                     w_full;
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.send_i};
  end

  assign w_send_s = r_sync[SYNC_STAGES-1];
  assign w_full   = (r_count == c_CNT_W'(DEPTH));
  assign w_pop    = (r_count != '0) && bus.out_ready;

  // Space is judged on the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_send_s) begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_state_n = S_ACK;
          end else begin
            w_state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!w_send_s) begin
          w_err_set = 1'b1;
          w_state_n = S_IDLE;
        end else if (!w_full) begin
          w_push    = 1'b1;
          w_state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_send_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ack   <= (w_state_n == S_ACK);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ack_o        = r_ack;
  assign bus.out_valid    = (r_count != '0);
  assign bus.out_data     = r_mem[r_rd_ptr];
  assign bus.count        = r_count;
  assign bus.protocol_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_hs4_rx_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hs4_rx_buffer : cycle vector table plus directed multi-cycle sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_hs4_rx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  hs4_rx_buffer_if #(.DATA_W(4), .DEPTH(4)) bus ();

  hs4_rx_buffer #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs apply before edge i; outputs are expected just after edge i.
  typedef struct packed {
    logic       rst;
    logic       send;
    logic [3:0] data;
    logic       rdy;
    logic       ack;
    logic       valid;
    logic [3:0] odata;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t       tbl [26];
  bit         mon_en = 1'b0;
  logic [3:0] got_q [$];
  int         max_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (bus.out_valid) got_q.push_back(bus.out_data);
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (bus.ack_o !== lvl && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(bus.ack_o), 32'(lvl));
  endtask

  task automatic send_word(input logic [3:0] d);
    bus.data_i = d;
    bus.send_i = 1'b1;
    wait_ack(1'b1, "ack_rise");
    bus.send_i = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    logic [3:0] exp4 [4];
    bit         ack_seen;

    bus.send_i    = 1'b0;
    bus.data_i    = 4'h0;
    bus.out_ready = 1'b0;

    //            rst send data  rdy  ack vld odata cnt  err
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 4'hA, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 4'hA, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 4'hA, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 4'hA, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'hB, 1'b0, 1'b0, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hB, 3'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1, 4'hB, 3'd2, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 4'hD, 1'b1, 1'b1, 1'b1, 4'hC, 3'd2, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 1'b1, 4'hD, 3'd1, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};

    for (int i = 0; i < 26; i++) begin
      rst           = tbl[i].rst;
      bus.send_i    = tbl[i].send;
      bus.data_i    = tbl[i].data;
      bus.out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_ack", i),   32'(bus.ack_o),        32'(tbl[i].ack));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid),    32'(tbl[i].valid));
      chk($sformatf("vec%0d_count", i), 32'(bus.count),        32'(tbl[i].cnt));
      chk($sformatf("vec%0d_err", i),   32'(bus.protocol_err), 32'(tbl[i].err));
      if (tbl[i].valid)
        chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].odata));
    end

    // Backpressure: fill, then word 5 must wait in HOLD until a slot opens.
    bus.out_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int w = 1; w <= 4; w++) send_word(4'(w));
    chk("bp_full_count", 32'(bus.count), 32'd4);
    bus.data_i = 4'h5;
    bus.send_i = 1'b1;
    ack_seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.ack_o) ack_seen = 1'b1;
    end
    chk("bp_hold_no_ack", 32'(ack_seen), 32'd0);
    chk("bp_hold_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_pop_head", 32'(bus.out_data), 32'h2);
    chk("bp_pop_count", 32'(bus.count), 32'd3);
    chk("bp_pop_no_ack", 32'(bus.ack_o), 32'd0);
    step();
    chk("bp_push_ack", 32'(bus.ack_o), 32'd1);
    chk("bp_push_count", 32'(bus.count), 32'd4);
    bus.send_i = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");

    // Abort from HOLD while full.
    bus.data_i = 4'h6;
    bus.send_i = 1'b1;
    ack_seen   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.ack_o) ack_seen = 1'b1;
    end
    bus.send_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.ack_o) ack_seen = 1'b1;
    end
    chk("abort_no_ack", 32'(ack_seen), 32'd0);
    chk("abort_err", 32'(bus.protocol_err), 32'd1);
    chk("abort_count", 32'(bus.count), 32'd4);

    exp4[0] = 4'h2; exp4[1] = 4'h3; exp4[2] = 4'h4; exp4[3] = 4'h5;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("drain%0d_data", k), 32'(bus.out_data), 32'(exp4[k]));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 32'(bus.count), 32'd0);

    send_word(4'hE);
    chk("post_abort_count", 32'(bus.count), 32'd1);
    chk("post_abort_data", 32'(bus.out_data), 32'hE);
    chk("post_abort_err", 32'(bus.protocol_err), 32'd1);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Reset while the FSM sits in ACK with three words buffered.
    send_word(4'h7);
    send_word(4'h8);
    bus.data_i = 4'h9;
    bus.send_i = 1'b1;
    wait_ack(1'b1, "rstmid_ack_rise");
    chk("rstmid_count_pre", 32'(bus.count), 32'd3);
    rst        = 1'b1;
    bus.send_i = 1'b0;
    step();
    chk("rstmid_ack", 32'(bus.ack_o), 32'd0);
    chk("rstmid_count", 32'(bus.count), 32'd0);
    chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_err", 32'(bus.protocol_err), 32'd0);
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.ack_o) ack_seen = 1'b1;
    end
    chk("rstmid_quiet", 32'(ack_seen), 32'd0);

    // Streaming with the consumer always ready: pointers wrap twice.
    bus.out_ready = 1'b1;
    mon_en = 1'b1;
    for (int w = 0; w < 10; w++) send_word(4'(w));
    step();
    mon_en = 1'b0;
    chk("wrap_words", 32'(got_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < got_q.size(); k++)
      chk($sformatf("wrap%0d_data", k), 32'(got_q[k]), 32'(k));
    chk("wrap_maxcnt_le1", 32'(max_cnt <= 1), 32'd1);
    chk("wrap_err", 32'(bus.protocol_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
